m_imem_loader: RTL and testbench



---
 rtl/m_imem_loader_if.sv | 25 ++
 rtl/m_imem_loader.sv | 130 +++++++++++++
 tb/tb_m_imem_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader side; the master modport is the stream source / memory side.
interface m_imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              w_in_valid;
    logic [7:0]        w_in_data;
    logic              w_in_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic              w_cpu_rst;
    logic              w_done;
    logic              w_err;

    modport master (
        output w_in_valid, w_in_data,
        input  w_in_ready, w_we, w_waddr, w_wdata, w_cpu_rst, w_done, w_err
    );

    modport slave (
        input  w_in_valid, w_in_data,
        output w_in_ready, w_we, w_waddr, w_wdata, w_cpu_rst, w_done, w_err
    );
endinterface

// File: rtl/m_imem_loader.sv
// Boot loader: byte stream (16-bit LE word count, then LE words) -> sequential imem writes.
// One byte per cycle; write pulse one cycle after the 4th byte; core reset released after last commit.
module m_imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    m_imem_loader_if.slave        bus
);
    typedef enum logic [2:0] {S_CNT0, S_CNT1, S_DATA, S_DONE, S_ERR} state_t;

    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       asm_q, asm_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [ADDR_W:0]   widx_inc;
    logic [16:0]       n_full;

    assign xfer     = bus.w_in_valid & ready_q;
    assign widx_inc = widx_q + 1'b1;
    assign n_full   = {1'b0, bus.w_in_data, cnt_q[7:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_CNT0: begin
                if (xfer) begin
                    cnt_d[7:0] = bus.w_in_data;
                    state_d    = S_CNT1;
                end
            end
            S_CNT1: begin
                if (xfer) begin
                    cnt_d[15:8] = bus.w_in_data;
                    widx_d      = '0;
                    bidx_d      = '0;
                    if (n_full == 17'd0) begin
                        state_d = S_DONE;
                    end else if (n_full > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    bidx_d = bidx_q + 2'd1;
                    // Bytes arrive LSB first, so shift new bytes in from the top.
                    asm_d  = {bus.w_in_data, asm_q[23:8]};
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = widx_q[ADDR_W-1:0];
                        wdata_d = {bus.w_in_data, asm_q};
                        widx_d  = widx_inc;
                        if (17'(widx_inc) == {1'b0, cnt_q}) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
            end
        endcase

        ready_d   = (state_d == S_CNT0) || (state_d == S_CNT1) || (state_d == S_DATA);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        // Release the core one cycle after done, so the final write has committed.
        cpu_rst_d = ~done_q;
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q   <= S_CNT0;
            cnt_q     <= '0;
            widx_q    <= '0;
            bidx_q    <= '0;
            asm_q     <= '0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            bidx_q    <= bidx_d;
            asm_q     <= asm_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.w_in_ready = ready_q;
    assign bus.w_we       = we_q;
    assign bus.w_waddr    = waddr_q;
    assign bus.w_wdata    = wdata_q;
    assign bus.w_cpu_rst  = cpu_rst_q;
    assign bus.w_done     = done_q;
    assign bus.w_err      = err_q;
endmodule

// File: tb/tb_m_imem_loader.sv
// Loader bench at a 16-word capacity: scoreboard of expected writes plus done/reset timing checks.
module tb_m_imem_loader;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_imem_loader_if #(.ADDR_W(AW)) bus ();
    m_imem_loader #(.ADDR_W(AW)) dut (.w_clk(clk), .w_rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    int   wr_count = 0;
    int   last_addr = -1;
    bq_t  s;
    logic [31:0] words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bq_t mk(input logic [15:0] n, input logic [31:0] w[$]);
        bq_t q;
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int j = 0; j < 4; j++) q.push_back(8'((w[i] >> (8 * j)) & 32'hFF));
        end
        return q;
    endfunction

    // Reference: every complete word k < N of the bytes actually sent is written to address k.
    function automatic void model(input bq_t b);
        int n;
        if (b.size() < 2) return;
        n = int'(b[0]) + 256 * int'(b[1]);
        if (n > CAP) return;
        for (int k = 0; k < n && (2 + 4 * k + 3) < b.size(); k++) begin
            wr_t e;
            e.addr = k;
            e.data = 32'(b[2+4*k]) + 32'(b[3+4*k]) * 32'h100
                   + 32'(b[4+4*k]) * 32'h10000 + 32'(b[5+4*k]) * 32'h1000000;
            exp_q.push_back(e);
        end
    endfunction

    // Ends at the negedge of the cycle after the final byte was accepted.
    task automatic send(input bq_t b, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < b.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", i, b.size());
                bus.w_in_valid = 1'b0;
                return;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.w_in_valid = 1'b0;
                bus.w_in_data  = 8'($urandom);
            end else begin
                bus.w_in_valid = 1'b1;
                bus.w_in_data  = b[i];
                if (bus.w_in_ready) i++;
            end
        end
        @(negedge clk);
        bus.w_in_valid = 1'b0;
    endtask

    task automatic load(input bq_t b, input int gap_pct);
        model(b);
        send(b, gap_pct);
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 32'(bus.w_done), 32'd1);
        chk({tag, "_cpu_rst_hold"}, 32'(bus.w_cpu_rst), 32'd1);
        chk({tag, "_ready_low"}, 32'(bus.w_in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_cpu_rst_rel"}, 32'(bus.w_cpu_rst), 32'd0);
        chk({tag, "_done_sticky"}, 32'(bus.w_done), 32'd1);
        chk({tag, "_err"}, 32'(bus.w_err), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.w_in_ready), 32'd1);
        chk({tag, "_we"}, 32'(bus.w_we), 32'd0);
        chk({tag, "_waddr"}, 32'(bus.w_waddr), 32'd0);
        chk({tag, "_wdata"}, bus.w_wdata, 32'd0);
        chk({tag, "_cpu_rst"}, 32'(bus.w_cpu_rst), 32'd1);
        chk({tag, "_done"}, 32'(bus.w_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.w_err), 32'd0);
    endtask

    // A byte offered alongside reset must be dropped.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.w_in_valid = 1'b1;
        bus.w_in_data  = 8'h5A;
        @(negedge clk);
        rst = 1'b0;
        bus.w_in_valid = 1'b0;
        exp_q.delete();
        wr_count  = 0;
        last_addr = -1;
        chk_reset("rst");
    endtask

    always @(negedge clk) begin
        if (!rst && bus.w_we) begin
            wr_count++;
            last_addr = int'(bus.w_waddr);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.w_waddr, bus.w_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("waddr", 32'(bus.w_waddr), 32'(e.addr));
                chk("wdata", bus.w_wdata, e.data);
            end
        end
    end

    initial begin
        bus.w_in_valid = 1'b0;
        bus.w_in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("init");

        // Program load, back-to-back
        words = {32'h00500093, 32'h00108133, 32'h00108093, 32'hFE209EE3, 32'h00908513, 32'h00050F13};
        s = mk(16'd6, words);
        load(s, 0);
        expect_done("prog");
        chk("prog_last_addr", 32'(last_addr), 32'd5);

        // Post-done input ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.w_in_valid = 1'b1;
            bus.w_in_data  = 8'($urandom);
            chk("post_ready", 32'(bus.w_in_ready), 32'd0);
        end
        @(negedge clk);
        bus.w_in_valid = 1'b0;
        chk("post_done", 32'(bus.w_done), 32'd1);
        chk("post_cpu_rst", 32'(bus.w_cpu_rst), 32'd0);
        chk("post_writes", 32'(wr_count), 32'd6);

        // Same program with valid gaps
        do_reset();
        load(s, 50);
        expect_done("gaps");
        chk("gaps_writes", 32'(wr_count), 32'd6);

        // Empty program
        do_reset();
        words = {};
        s = mk(16'd0, words);
        load(s, 0);
        expect_done("n0");
        chk("n0_writes", 32'(wr_count), 32'd0);

        // Exactly full memory
        do_reset();
        words = {};
        for (int i = 0; i < CAP; i++) words.push_back($urandom);
        s = mk(16'(CAP), words);
        load(s, 30);
        expect_done("full");
        chk("full_last_addr", 32'(last_addr), 32'(CAP - 1));
        chk("full_writes", 32'(wr_count), 32'(CAP));

        // One word over capacity
        do_reset();
        words = {};
        s = mk(16'(CAP + 1), words);
        load(s, 0);
        chk("ovf_err", 32'(bus.w_err), 32'd1);
        chk("ovf_ready", 32'(bus.w_in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.w_in_valid = 1'b1;
            bus.w_in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.w_in_valid = 1'b0;
        chk("ovf_err_sticky", 32'(bus.w_err), 32'd1);
        chk("ovf_cpu_rst", 32'(bus.w_cpu_rst), 32'd1);
        chk("ovf_done", 32'(bus.w_done), 32'd0);
        chk("ovf_writes", 32'(wr_count), 32'd0);

        // Reset after two bytes of word 3, then a fresh one-word load
        do_reset();
        words = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hCAFEF00D, 32'h0BADBEEF};
        s = mk(16'd5, words);
        while (s.size() > 2 + 4 * 3 + 2) void'(s.pop_back());
        load(s, 0);
        repeat (2) @(negedge clk);
        chk("mid_writes", 32'(wr_count), 32'd3);
        chk("mid_queue", 32'(exp_q.size()), 32'd0);
        do_reset();
        words = {32'hDEADBEEF};
        s = mk(16'd1, words);
        load(s, 0);
        expect_done("fresh");
        chk("fresh_writes", 32'(wr_count), 32'd1);
        chk("fresh_addr", 32'(last_addr), 32'd0);

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
